// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the dual-camera SCCB config scheduler.
// Scheduler states, ROM marker words and camera indices.
package sccb_cfg_pkg;

  typedef enum logic [2:0] {
    BOOT_FETCH,
    BOOT_DECODE,
    ISSUE,
    WAIT_DONE,
    DELAY,
    IDLE_RUN
  } state_t;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  localparam logic CAM_DICE = 1'b0;
  localparam logic CAM_FACE = 1'b1;

endpackage

// File: rtl/sccb_cfg_scheduler_rr_arb2.sv
// Two-way round-robin arbiter for the runtime register-write requesters.
// The last-grant register moves only when a granted write is accepted.
module rr_arb2
  import sccb_cfg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  input  logic       adv_idx_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // Contention goes to whichever requester was not served last.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  // Reset as if CAM_FACE was served last so req0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= CAM_FACE;
    end else if (adv_i) begin
      last_q <= adv_idx_i;
    end
  end

endmodule

// File: rtl/sccb_cfg_scheduler.sv
// Boot-table walker and runtime write arbiter for both OV7670 cameras.
// Drives one shared SCCB write engine; one write outstanding at a time.
module sccb_cfg_scheduler
  import sccb_cfg_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RST_WAIT = 100_000,
  parameter int TIMEOUT  = 2_000_000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cfg_restart_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic              wr_cam_o,
  output logic [7:0]        wr_reg_o,
  output logic [7:0]        wr_val_o,
  input  logic              wr_done_i,
  input  logic [1:0]        req_valid_i,
  input  logic [15:0]       req_reg_i,
  input  logic [15:0]       req_val_i,
  output logic [1:0]        req_gnt_o,
  output logic              cfg_done_o,
  output logic              busy_o,
  output logic              cfg_err_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT - 1);
  localparam logic [31:0] DLY_LIM = 32'(RST_WAIT - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              wr_valid_q;
  logic              wr_cam_q;
  logic [7:0]        wr_reg_q;
  logic [7:0]        wr_val_q;
  logic [1:0]        own_q;
  logic              cfg_done_q;
  logic              busy_q;
  logic              cfg_err_q;
  logic              boot_q;
  logic              rst_pend_q;
  logic [31:0]       tmo_q;
  logic [31:0]       dly_q;

  logic        accept;
  logic        tmo_hit;
  logic [31:0] tmo_d;
  logic [1:0]  arb_req;
  logic [1:0]  arb_gnt;

  assign accept  = wr_valid_q & wr_ready_i;
  assign tmo_hit = (tmo_q >= TMO_LIM);
  assign tmo_d   = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;
  assign arb_req = (cfg_done_q & ~cfg_restart_i) ? req_valid_i : 2'b00;

  rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .req_i     (arb_req),
    .adv_i     (accept & ~boot_q),
    .adv_idx_i (wr_cam_q),
    .gnt_o     (arb_gnt)
  );

  assign rom_addr_o = rom_addr_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_cam_o   = wr_cam_q;
  assign wr_reg_o   = wr_reg_q;
  assign wr_val_o   = wr_val_q;
  // Grant coincides with the engine handshake of the owner's write.
  assign req_gnt_o  = own_q & {2{accept}};
  assign cfg_done_o = cfg_done_q;
  assign busy_o     = busy_q;
  assign cfg_err_o  = cfg_err_q;

  // Main sequencer: boot walk, runtime service, restart and timeout.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= BOOT_FETCH;
      rom_addr_q <= '0;
      wr_valid_q <= 1'b0;
      wr_cam_q   <= CAM_DICE;
      wr_reg_q   <= 8'h00;
      wr_val_q   <= 8'h00;
      own_q      <= 2'b00;
      cfg_done_q <= 1'b0;
      busy_q     <= 1'b1;
      cfg_err_q  <= 1'b0;
      boot_q     <= 1'b1;
      rst_pend_q <= 1'b0;
      tmo_q      <= '0;
      dly_q      <= '0;
    end else begin
      busy_q <= 1'b1;
      if (cfg_restart_i && state_q != WAIT_DONE &&
          !(state_q == ISSUE && wr_ready_i)) begin
        state_q    <= BOOT_FETCH;
        rom_addr_q <= '0;
        wr_valid_q <= 1'b0;
        wr_cam_q   <= CAM_DICE;
        own_q      <= 2'b00;
        cfg_done_q <= 1'b0;
        boot_q     <= 1'b1;
        rst_pend_q <= 1'b0;
      end else begin
        unique case (state_q)
          BOOT_FETCH: begin
            state_q <= BOOT_DECODE;
          end
          BOOT_DECODE: begin
            if (rom_data_i == CFG_END) begin
              cfg_done_q <= 1'b1;
              boot_q     <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= IDLE_RUN;
            end else if (rom_data_i == CFG_DELAY) begin
              dly_q   <= '0;
              state_q <= DELAY;
            end else begin
              wr_reg_q   <= rom_data_i[15:8];
              wr_val_q   <= rom_data_i[7:0];
              wr_cam_q   <= CAM_DICE;
              own_q      <= 2'b00;
              wr_valid_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
          ISSUE: begin
            if (wr_ready_i) begin
              wr_valid_q <= 1'b0;
              tmo_q      <= '0;
              rst_pend_q <= cfg_restart_i;
              state_q    <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            tmo_q <= tmo_d;
            if (cfg_restart_i) begin
              rst_pend_q <= 1'b1;
            end
            if (wr_done_i || tmo_hit) begin
              if (!wr_done_i) begin
                cfg_err_q <= 1'b1;
              end
              if (rst_pend_q || cfg_restart_i) begin
                state_q    <= BOOT_FETCH;
                rom_addr_q <= '0;
                wr_cam_q   <= CAM_DICE;
                own_q      <= 2'b00;
                cfg_done_q <= 1'b0;
                boot_q     <= 1'b1;
                rst_pend_q <= 1'b0;
              end else if (!boot_q) begin
                own_q   <= 2'b00;
                busy_q  <= 1'b0;
                state_q <= IDLE_RUN;
              end else if (wr_cam_q == CAM_DICE) begin
                wr_cam_q   <= CAM_FACE;
                wr_valid_q <= 1'b1;
                state_q    <= ISSUE;
              end else if (rom_addr_q == LAST_ADDR) begin
                cfg_done_q <= 1'b1;
                boot_q     <= 1'b0;
                busy_q     <= 1'b0;
                state_q    <= IDLE_RUN;
              end else begin
                rom_addr_q <= rom_addr_q + ADDR_ONE;
                state_q    <= BOOT_FETCH;
              end
            end
          end
          DELAY: begin
            dly_q <= dly_q + 32'd1;
            if (dly_q >= DLY_LIM) begin
              if (rom_addr_q == LAST_ADDR) begin
                cfg_done_q <= 1'b1;
                boot_q     <= 1'b0;
                busy_q     <= 1'b0;
                state_q    <= IDLE_RUN;
              end else begin
                rom_addr_q <= rom_addr_q + ADDR_ONE;
                state_q    <= BOOT_FETCH;
              end
            end
          end
          IDLE_RUN: begin
            if (|arb_gnt) begin
              wr_cam_q   <= arb_gnt[1];
              wr_reg_q   <= arb_gnt[1] ? req_reg_i[15:8] : req_reg_i[7:0];
              wr_val_q   <= arb_gnt[1] ? req_val_i[15:8] : req_val_i[7:0];
              own_q      <= arb_gnt;
              wr_valid_q <= 1'b1;
              state_q    <= ISSUE;
            end else begin
              busy_q <= 1'b0;
            end
          end
          default: begin
            state_q <= BOOT_FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_cfg_scheduler.sv
// Scoreboard bench for sccb_cfg_scheduler with ROM and SCCB engine models.
// Expected writes are queued by stimulus; a negedge monitor checks them.
module tb_sccb_cfg_scheduler;
  import sccb_cfg_pkg::*;

  localparam int AW = 3;
  localparam int RW = 20;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_restart = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic          wr_cam;
  logic [7:0]    wr_reg;
  logic [7:0]    wr_val;
  logic          wr_done = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [15:0]   req_reg = 16'h0;
  logic [15:0]   req_val = 16'h0;
  logic [1:0]    req_gnt;
  logic          cfg_done;
  logic          busy;
  logic          cfg_err;

  typedef struct packed {
    logic       cam;
    logic [7:0] r;
    logic [7:0] v;
    logic [1:0] g;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   cnt = 0;
  int   done_lat = 5;
  bit   done_en = 1'b1;
  logic [15:0] rom [8];

  sccb_cfg_scheduler #(
    .ADDR_W(AW), .RST_WAIT(RW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset), .cfg_restart_i(cfg_restart),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .wr_cam_o(wr_cam), .wr_reg_o(wr_reg), .wr_val_o(wr_val),
    .wr_done_i(wr_done), .req_valid_i(req_valid),
    .req_reg_i(req_reg), .req_val_i(req_val), .req_gnt_o(req_gnt),
    .cfg_done_o(cfg_done), .busy_o(busy), .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB engine: done pulse done_lat edges after acceptance
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      if (cnt == 1 && done_en) begin
        wr_done <= 1'b1;
        n_done  <= n_done + 1;
      end
      if (cnt > 0) cnt <= cnt - 1;
      if (wr_valid && wr_ready) cnt <= done_lat;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted write is matched against the queue head
  always @(negedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_write", {13'h0, wr_cam, wr_reg, wr_val, req_gnt},
            32'h7FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write", {13'h0, wr_cam, wr_reg, wr_val, req_gnt},
            {13'h0, e});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic c, input logic [7:0] r,
                      input logic [7:0] v, input logic [1:0] g);
    exp_t e;
    e = '{cam: c, r: r, v: v, g: g};
    sb.push_back(e);
  endtask

  task automatic push_boot4();
    push(1'b0, 8'h12, 8'h80, 2'b00);
    push(1'b1, 8'h12, 8'h80, 2'b00);
    push(1'b0, 8'h12, 8'h04, 2'b00);
    push(1'b1, 8'h12, 8'h04, 2'b00);
  endtask

  task automatic load_std();
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1204;
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, {7'h0, wr_valid, wr_cam, wr_reg, wr_val, req_gnt,
             cfg_done, busy, cfg_err, rom_addr},
        {7'h0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00,
         1'b0, 1'b1, 1'b0, 3'd0});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_cfg(input int budget);
    int n = 0;
    while (!cfg_done && n < budget) begin
      tick();
      n++;
    end
    chk("cfg_done_reached", cfg_done, 1);
  endtask

  task automatic wait_sb(input string nm, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, sb.size(), 0);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(nm, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int bad;
    int t0;

    // reset state and boot walk
    load_std();
    tick(3);
    chk_rst("reset_state");
    push_boot4();
    base = n_done;
    reset = 1'b0;
    wait_cfg(1000);
    chk("done_cnt_at_cfg_done", n_done - base, 4);
    chk("busy_low_at_cfg_done", busy, 0);
    chk("boot_cfg_err", cfg_err, 0);
    wait_sb("boot_writes", 10);
    chk("delay_gap", (acc_cyc.size() >= 3) &&
        (acc_cyc[2] - acc_cyc[1] > RW), 1);

    // round-robin with both requesters held
    push(1'b0, 8'h10, 8'hAA, 2'b01);
    push(1'b1, 8'h3A, 8'h55, 2'b10);
    push(1'b0, 8'h10, 8'hAA, 2'b01);
    push(1'b1, 8'h3A, 8'h55, 2'b10);
    req_reg = {8'h3A, 8'h10};
    req_val = {8'h55, 8'hAA};
    req_valid = 2'b11;
    wait_sb("rr_grants", 200);
    req_valid = 2'b00;
    wait_idle("rr_idle", 50);

    // backpressure on a single req0 write
    wr_ready = 1'b0;
    req_reg[7:0] = 8'h20;
    req_val[7:0] = 8'h33;
    req_valid = 2'b01;
    push(1'b0, 8'h20, 8'h33, 2'b01);
    base = acc_cnt;
    tick();
    chk("req_to_valid_1cyc", wr_valid, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({wr_valid, wr_cam, wr_reg, wr_val, req_gnt} !==
          {1'b1, 1'b0, 8'h20, 8'h33, 2'b00}) bad++;
      tick();
    end
    chk("bp_hold_stable", bad, 0);
    chk("bp_no_accept", acc_cnt - base, 0);
    wr_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    wait_idle("bp_idle", 50);
    chk("bp_one_accept", acc_cnt - base, 1);

    // restart while a runtime write is outstanding
    req_reg[7:0] = 8'h44;
    req_val[7:0] = 8'h11;
    req_valid = 2'b01;
    push(1'b0, 8'h44, 8'h11, 2'b01);
    wait_sb("rs_accept", 20);
    req_valid = 2'b10;
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
    push_boot4();
    n = 0;
    while (!wr_done && n < 20) begin
      tick();
      n++;
    end
    chk("rs_done_seen", wr_done, 1);
    tick();
    chk("rs_cfg_done_clr", cfg_done, 0);
    chk("rs_addr0", rom_addr, 0);
    tick(5);
    req_valid = 2'b00;
    wait_cfg(1000);
    wait_sb("rs_boot_writes", 10);

    // timeout: engine never completes
    done_en = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    acc_cyc.delete();
    push(1'b0, 8'h12, 8'h80, 2'b00);
    push(1'b1, 8'h12, 8'h80, 2'b00);
    do_reset();
    n = 0;
    while (!cfg_err && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_err_set", cfg_err, 1);
    // first visible after the TIMEOUT-th edge past the acceptance edge
    t0 = (acc_cyc.size() > 0) ? acc_cyc[0] : 0;
    chk("tmo_latency", cyc - t0, TO + 1);
    wait_cfg(500);
    chk("tmo_err_sticky", cfg_err, 1);
    wait_sb("tmo_writes", 10);
    done_en = 1'b1;

    // done arriving on the expiry cycle is not an error
    done_lat = TO - 1;
    push(1'b0, 8'h12, 8'h80, 2'b00);
    push(1'b1, 8'h12, 8'h80, 2'b00);
    do_reset();
    wait_cfg(500);
    chk("done_at_expiry_no_err", cfg_err, 0);
    wait_sb("expiry_writes", 10);
    done_lat = 5;

    // last address is processed then ends the table
    for (int i = 0; i < 7; i++) rom[i] = 16'hFFF0;
    rom[7] = 16'h3301;
    push(1'b0, 8'h33, 8'h01, 2'b00);
    push(1'b1, 8'h33, 8'h01, 2'b00);
    do_reset();
    wait_cfg(1000);
    chk("ovf_addr_hold", rom_addr, 7);
    wait_sb("ovf_writes", 10);
    tick(30);
    chk("ovf_stays_done", {busy, cfg_done}, 2'b01);

    // async reset in the middle of a delay
    load_std();
    push(1'b0, 8'h12, 8'h80, 2'b00);
    push(1'b1, 8'h12, 8'h80, 2'b00);
    do_reset();
    n = 0;
    while (rom_addr != 3'd1 && n < 200) begin
      tick();
      n++;
    end
    chk("ar_at_delay_addr", rom_addr, 1);
    tick(5);
    chk("ar_pre_writes", sb.size(), 0);
    #2 reset = 1'b1;
    #1 chk_rst("async_reset_vals");
    push_boot4();
    tick(2);
    reset = 1'b0;
    wait_cfg(1000);
    wait_sb("ar_reboot_writes", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
